// File: rtl/pointer_register.sv
// -----------------------------------------------------------------------------
// pointer_register
//
// Address pointer for the brightness-control BCM path. Each completed
// operation (a rising edge of operation_dn) advances the pointer by one. After
// ADDR_MAX the pointer returns to START_ADDR, and wrap pulses for one cycle.
// operation_dn may be asynchronous to clk. It is brought into the clk domain
// through a SYNC_STAGES-deep flop chain before its edge is detected.
//
// Parameters:
//   ADDR_W      - pointer width
//   START_ADDR  - reset value and wrap target (START_ADDR <= ADDR_MAX)
//   ADDR_MAX    - last valid address; the next event wraps to START_ADDR
//   SYNC_STAGES - synchronizer depth on operation_dn (minimum 2)
//
// Ports:
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   operation_dn in   "operation done" strobe, possibly asynchronous
//   address      out  current pointer value (registered)
//   wrap         out  one-cycle pulse when address returns to START_ADDR
// -----------------------------------------------------------------------------
module pointer_register #(
    parameter int ADDR_W      = 7,
    parameter int START_ADDR  = 0,
    parameter int ADDR_MAX    = 127,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              operation_dn,
    output logic [ADDR_W-1:0] address,
    output logic              wrap
);

    localparam logic [ADDR_W-1:0] START_VAL = ADDR_W'(START_ADDR);
    localparam logic [ADDR_W-1:0] MAX_VAL   = ADDR_W'(ADDR_MAX);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   hist_reg;
    logic                   op_event;

    logic [ADDR_W-1:0]      address_reg;
    logic [ADDR_W-1:0]      address_next;
    logic                   wrap_reg;
    logic                   wrap_next;

    // Synchronizer chain and edge-history flop. Bit 0 is the first stage, and
    // the last stage feeds edge detection. Reset clears the whole chain. This
    // discards any event in flight. It also means a strobe that is already
    // high at release is seen as a fresh rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg <= '0;
            hist_reg <= 1'b0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], operation_dn};
            hist_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    // A level held high produces one event only, because hist_reg follows the
    // synchronized value one cycle later.
    assign op_event = sync_reg[SYNC_STAGES-1] & ~hist_reg;

    // The wrap is decided by an explicit compare against ADDR_MAX. This gives
    // the same result whether or not ADDR_MAX is the all-ones value.
    always_comb begin
        address_next = address_reg;
        wrap_next    = 1'b0;
        if (op_event) begin
            if (address_reg == MAX_VAL) begin
                address_next = START_VAL;
                wrap_next    = 1'b1;
            end else begin
                address_next = address_reg + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            address_reg <= START_VAL;
            wrap_reg    <= 1'b0;
        end else begin
            address_reg <= address_next;
            wrap_reg    <= wrap_next;
        end
    end

    assign address = address_reg;
    assign wrap    = wrap_reg;

endmodule

// File: tb/tb_pointer_register.sv
// -----------------------------------------------------------------------------
// tb_pointer_register
//
// Drives two pointer instances from the same stimulus:
//   - dut_a uses the default parameters (0..127).
//   - dut_b uses START_ADDR=4 and ADDR_MAX=9.
// Each operation_dn rising edge pushes the expected address, the expected wrap
// value and the expected change cycle into a per-DUT queue. A monitor pops and
// compares the entry whenever the DUT address moves. It also checks that wrap
// stays low on idle cycles.
// -----------------------------------------------------------------------------
module tb_pointer_register;

    typedef struct {
        logic [6:0] addr;
        logic       wrap;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       op = 1'b0;
    logic [6:0] addr_a, addr_b;
    logic       wrap_a, wrap_b;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t qa[$];
    exp_t qb[$];
    logic [6:0] model_a = 7'd0;
    logic [6:0] model_b = 7'd4;
    logic [6:0] prev_a, prev_b;

    pointer_register dut_a (
        .clk          (clk),
        .rst_n        (rst_n),
        .operation_dn (op),
        .address      (addr_a),
        .wrap         (wrap_a)
    );

    pointer_register #(
        .ADDR_W      (7),
        .START_ADDR  (4),
        .ADDR_MAX    (9),
        .SYNC_STAGES (2)
    ) dut_b (
        .clk          (clk),
        .rst_n        (rst_n),
        .operation_dn (op),
        .address      (addr_b),
        .wrap         (wrap_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance both reference pointers once, then queue the expected results.
    task automatic step_models(input int due);
        exp_t e;
        e.due  = due;
        e.wrap = (model_a == 7'd127);
        model_a = e.wrap ? 7'd0 : model_a + 7'd1;
        e.addr = model_a;
        qa.push_back(e);
        e.wrap = (model_b == 7'd9);
        model_b = e.wrap ? 7'd4 : model_b + 7'd1;
        e.addr = model_b;
        qb.push_back(e);
    endtask

    // The rise happens 6 ns after an edge. It is first sampled on the next
    // edge, and the address moves two edges after that.
    task automatic pulse(input int hi, input int lo);
        @(posedge clk); #6;
        op = 1'b1;
        step_models(cyc + 3);
        repeat (hi) @(posedge clk);
        #6;
        op = 1'b0;
        repeat (lo) @(posedge clk);
    endtask

    task automatic drain();
        repeat (8) @(posedge clk);
        #2;
        chk("a_queue_drained", qa.size(), 0);
        chk("b_queue_drained", qb.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("a_async_reset_addr", addr_a, 0);
        chk("b_async_reset_addr", addr_b, 4);
        chk("a_async_reset_wrap", wrap_a, 0);
        model_a = 7'd0;
        model_b = 7'd4;
        qa.delete();
        qb.delete();
        repeat (2) @(posedge clk);
        #6;
        rst_n = 1'b1;
    endtask

    // Monitor: runs 1 ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            prev_a = addr_a;
            prev_b = addr_b;
        end else begin
            if (addr_a !== prev_a) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_step", addr_a, prev_a);
                end else begin
                    e = qa.pop_front();
                    chk("a_addr", addr_a, e.addr);
                    chk("a_wrap", wrap_a, e.wrap);
                    chk("a_latency_cycle", cyc, e.due);
                end
                prev_a = addr_a;
            end else begin
                chk("a_wrap_idle", wrap_a, 0);
            end
            if (addr_b !== prev_b) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_step", addr_b, prev_b);
                end else begin
                    e = qb.pop_front();
                    chk("b_addr", addr_b, e.addr);
                    chk("b_wrap", wrap_b, e.wrap);
                    chk("b_latency_cycle", cyc, e.due);
                end
                prev_b = addr_b;
            end else begin
                chk("b_wrap_idle", wrap_b, 0);
            end
        end
    end

    initial begin
        // Reset held while operation_dn toggles randomly.
        rst_n = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #3;
            op = 1'($urandom_range(0, 1));
            #1;
            chk("a_reset_addr", addr_a, 0);
            chk("a_reset_wrap", wrap_a, 0);
            chk("b_reset_addr", addr_b, 4);
        end
        op = 1'b0;
        repeat (3) @(posedge clk);
        #6;
        rst_n = 1'b1;

        // Three short pulses: one period high, one period low.
        repeat (3) pulse(1, 0);
        drain();
        chk("a_three_pulses", addr_a, 3);

        // A held level counts once. Low then high again counts once more.
        do_reset();
        pulse(20, 3);
        drain();
        chk("a_held_level", addr_a, 1);
        pulse(2, 3);
        drain();
        chk("a_held_then_again", addr_a, 2);

        // Parameterized wrap on dut_b, then a full wrap on dut_a.
        do_reset();
        repeat (5) pulse(2, 2);
        drain();
        chk("b_reach_max", addr_b, 9);
        pulse(2, 2);
        drain();
        chk("b_wrapped", addr_b, 4);
        repeat (121) pulse(2, 2);
        drain();
        chk("a_reach_127", addr_a, 127);
        pulse(2, 2);
        drain();
        chk("a_wrapped", addr_a, 0);
        pulse(2, 2);
        drain();
        chk("a_after_wrap", addr_a, 1);

        // Reset mid-count, then release with operation_dn already high.
        do_reset();
        repeat (5) pulse(2, 2);
        drain();
        chk("a_count_to_5", addr_a, 5);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("a_mid_reset_addr", addr_a, 0);
        chk("b_mid_reset_addr", addr_b, 4);
        model_a = 7'd0;
        model_b = 7'd4;
        op = 1'b1;
        repeat (2) @(posedge clk);
        #6;
        rst_n = 1'b1;
        step_models(cyc + 3);
        repeat (5) @(posedge clk);
        #6;
        op = 1'b0;
        drain();
        chk("a_release_high", addr_a, 1);
        chk("b_release_high", addr_b, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/pointer_register.md
# pointer_register

Address pointer for the brightness-control BCM path. It counts completed operations: each rising edge of the `operation_dn` strobe advances a 7-bit address pointer by one, and the pointer wraps back to the start address after the last location. The output `address` indexes the downstream brightness/bit-plane memory. `operation_dn` may arrive asynchronously to `clk`, so the block synchronizes it internally.

## Interface
- `ADDR_W`, default 7: address width.
- `START_ADDR`, default 0: reset value and wrap target; must satisfy `START_ADDR <= ADDR_MAX`.
- `ADDR_MAX`, default 127: last valid address; the next increment wraps to `START_ADDR`.
- `SYNC_STAGES`, default 2 (minimum 2): synchronizer flops on `operation_dn`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `operation_dn`  input  1  "operation done" strobe; may be asynchronous to `clk`.
- `address`  output  ADDR_W  current pointer value, registered.
- `wrap`  output  1  one-cycle pulse on the cycle `address` goes from `ADDR_MAX` to `START_ADDR`.

## Operation
- Synchronization:
  - `operation_dn` passes through a `SYNC_STAGES`-deep flop chain.
  - A history flop holds the previous synchronized value.
  - Event = synchronized value 1 AND history value 0, i.e. a rising edge.
- Each event advances the pointer exactly once:
  - If `address == ADDR_MAX`: `address <= START_ADDR` and `wrap <= 1`.
  - Otherwise: `address <= address + 1` and `wrap <= 0`.
- A level held high produces one event only. A falling edge does nothing.
- With no event, `address` holds and `wrap` is 0.
- Arithmetic is unsigned, ADDR_W bits.
- If `ADDR_MAX = 2^ADDR_W - 1`, wrap happens by the explicit compare, not by overflow alone. The result must be identical either way.
- Reset (`rst_n` low, asynchronous):
  - `address = START_ADDR`, `wrap = 0`.
  - All synchronizer and history flops = 0.
- Reset mid-operation:
  - Takes effect immediately.
  - Any event in flight is discarded.
- After reset release, if `operation_dn` is already high, this counts as one rising edge: the pointer advances once after the synchronizer latency.
- Pulses shorter than the minimum width may be missed. Missing such a pulse is legal. Counting it twice is never legal.

## Timing
- Latency: `address` changes on the (`SYNC_STAGES`+1)th rising `clk` edge after `operation_dn` is first sampled high. That is 3 edges with defaults.
- `wrap` is asserted for exactly one `clk` cycle, coincident with `address == START_ADDR` after a wrap.
- Minimum `operation_dn` high time: 2 `clk` periods. Minimum low time: 2 `clk` periods. Pulses meeting both are all counted.
- Maximum event rate: one increment per 4 `clk` cycles.
- No combinational path from any input to any output.

## Test plan
- Reset:
  - Hold `rst_n` = 0 with random `operation_dn` -> `address` = 0, `wrap` = 0.
  - Pulse `operation_dn` during reset -> no change.
- Three pulses: `clk` 10 ns, `operation_dn` 0 until 21 ns, then 10 ns high / 10 ns low ×3 -> `address` steps 0→1→2→3. Each step occurs 3 clock edges after the rising edge; final value 3.
- Held level: `operation_dn` high for 20 cycles -> `address` 0→1 once, no further change; low then high again -> 2.
- Wrap, defaults: 127 valid pulses -> `address` = 127; one more pulse -> `address` = 0 with `wrap` high for exactly one cycle; next pulse -> 1, `wrap` stays 0.
- Parameterized wrap: `START_ADDR` = 4, `ADDR_MAX` = 9 -> reset value 4; 5 pulses reach 9; 6th pulse -> 4 with `wrap` pulse.
- Reset mid-count:
  - Count to 5, then assert `rst_n` low asynchronously between clock edges -> `address` = 0 immediately.
  - Release with `operation_dn` high -> `address` = 1 three edges later.
